// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush/redirect controller with data-memory wait sequencing
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs1Reg,
    input  logic [4:0]  ID_rs2Reg,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rdReg,
    input  logic        MEM_Branch,
    input  logic        MEM_Jump,
    input  logic        MEM_zero,
    input  logic        MEM_s_less,
    input  logic        MEM_u_less,
    input  logic [2:0]  MEM_funct3,
    input  logic [63:0] MEM_PCSum,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        dmem_ready,
    output logic        PCSrc,
    output logic [63:0] PCtarget,
    output logic        PCwrite,
    output logic        IDwrite,
    output logic        IDflush,
    output logic        EXflush,
    output logic        MEMflush,
    output logic        pipe_hold,
    output logic        dmem_req,
    output logic        mem_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_lu_cnt,
    output logic [CNT_W-1:0] perf_redir_cnt,
    output logic [CNT_W-1:0] perf_wait_cyc
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_ERROR   = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t     state, state_n;
    logic [7:0] wait_cnt, wait_cnt_n;

    logic acc;
    logic taken;
    logic hold_req;
    logic redir;
    logic lu;
    logic redir_win;
    logic lu_win;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (MEM_funct3)
            3'b000:  taken = MEM_zero;
            3'b001:  taken = ~MEM_zero;
            3'b100:  taken = MEM_s_less;
            3'b101:  taken = ~MEM_s_less;
            3'b110:  taken = MEM_u_less;
            3'b111:  taken = ~MEM_u_less;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        PCSrc      = 1'b0;
        PCtarget   = MEM_PCSum;
        PCwrite    = 1'b1;
        IDwrite    = 1'b1;
        IDflush    = 1'b0;
        EXflush    = 1'b0;
        MEMflush   = 1'b0;
        pipe_hold  = 1'b0;
        dmem_req   = 1'b0;
        mem_err    = 1'b0;
        redir_win  = 1'b0;
        lu_win     = 1'b0;

        acc      = MEM_MemRead | MEM_MemWrite;
        hold_req = acc & ~dmem_ready;
        redir    = MEM_Jump | (MEM_Branch & taken);
        lu       = EX_MemRead & (EX_rdReg != 5'd0) &
                   ((EX_rdReg == ID_rs1Reg) | (EX_rdReg == ID_rs2Reg));

        case (state)
            ST_RUN: begin
                if (hold_req) begin
                    state_n    = ST_MEMWAIT;
                    wait_cnt_n = 8'd1;
                end
            end
            ST_MEMWAIT: begin
                if (dmem_ready) begin
                    state_n = ST_RUN;
                end else if (wait_cnt == TIMEOUT_C) begin
                    state_n = ST_ERROR;
                end else begin
                    wait_cnt_n = wait_cnt + 8'd1;
                end
            end
            default: state_n = ST_ERROR;
        endcase

        if (state == ST_ERROR) begin
            PCwrite   = 1'b0;
            IDwrite   = 1'b0;
            pipe_hold = 1'b1;
            mem_err   = 1'b1;
        end else begin
            dmem_req = acc;
            // Frozen MEM contents mean any pending redirect is simply re-seen on release.
            if (hold_req) begin
                pipe_hold = 1'b1;
                PCwrite   = 1'b0;
                IDwrite   = 1'b0;
            end else if (redir) begin
                redir_win = 1'b1;
                PCSrc     = 1'b1;
                IDflush   = 1'b1;
                EXflush   = 1'b1;
                MEMflush  = 1'b1;
            end else if (lu) begin
                lu_win  = 1'b1;
                PCwrite = 1'b0;
                IDwrite = 1'b0;
                EXflush = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cyc <= '0;
            perf_lu_cnt    <= '0;
            perf_redir_cnt <= '0;
            perf_wait_cyc  <= '0;
        end else begin
            if (!PCwrite && !(&perf_stall_cyc))
                perf_stall_cyc <= perf_stall_cyc + 1'b1;
            if (lu_win && !(&perf_lu_cnt))
                perf_lu_cnt <= perf_lu_cnt + 1'b1;
            if (redir_win && !(&perf_redir_cnt))
                perf_redir_cnt <= perf_redir_cnt + 1'b1;
            if (pipe_hold && !(&perf_wait_cyc))
                perf_wait_cyc <= perf_wait_cyc + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs1Reg, ID_rs2Reg, EX_rdReg;
    logic        EX_MemRead, MEM_Branch, MEM_Jump, MEM_zero, MEM_s_less, MEM_u_less;
    logic [2:0]  MEM_funct3;
    logic [63:0] MEM_PCSum;
    logic        MEM_MemRead, MEM_MemWrite, dmem_ready;
    logic        PCSrc, PCwrite, IDwrite, IDflush, EXflush, MEMflush, pipe_hold, dmem_req, mem_err;
    logic [63:0] PCtarget;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc, perf_lu_cnt, perf_redir_cnt, perf_wait_cyc;
`endif

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .ID_rs1Reg(ID_rs1Reg), .ID_rs2Reg(ID_rs2Reg),
        .EX_MemRead(EX_MemRead), .EX_rdReg(EX_rdReg),
        .MEM_Branch(MEM_Branch), .MEM_Jump(MEM_Jump), .MEM_zero(MEM_zero),
        .MEM_s_less(MEM_s_less), .MEM_u_less(MEM_u_less), .MEM_funct3(MEM_funct3),
        .MEM_PCSum(MEM_PCSum), .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .dmem_ready(dmem_ready),
        .PCSrc(PCSrc), .PCtarget(PCtarget), .PCwrite(PCwrite), .IDwrite(IDwrite),
        .IDflush(IDflush), .EXflush(EXflush), .MEMflush(MEMflush),
        .pipe_hold(pipe_hold), .dmem_req(dmem_req), .mem_err(mem_err)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc), .perf_lu_cnt(perf_lu_cnt),
        .perf_redir_cnt(perf_redir_cnt), .perf_wait_cyc(perf_wait_cyc)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = running, 1 = waiting on memory, 2 = fatal timeout.
    int m_mode  = 0;
    int m_waits = 0;

    function automatic logic [72:0] model_out();
        bit err, acc, hold, tk, rd, lu, lu_w;
        err  = (m_mode == 2);
        acc  = MEM_MemRead || MEM_MemWrite;
        hold = !err && acc && !dmem_ready;
        case (MEM_funct3)
            3'd0: tk = MEM_zero;
            3'd1: tk = !MEM_zero;
            3'd4: tk = MEM_s_less;
            3'd5: tk = !MEM_s_less;
            3'd6: tk = MEM_u_less;
            3'd7: tk = !MEM_u_less;
            default: tk = 0;
        endcase
        rd   = !err && !hold && (MEM_Jump || (MEM_Branch && tk));
        lu   = EX_MemRead && EX_rdReg != 0 && (EX_rdReg == ID_rs1Reg || EX_rdReg == ID_rs2Reg);
        lu_w = !err && !hold && !rd && lu;
        return {rd, MEM_PCSum, !(err || hold || lu_w), !(err || hold || lu_w),
                rd, rd || lu_w, rd, err || hold, !err && acc, err};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0; m_waits = 0;
        end else if (m_mode == 0) begin
            if ((MEM_MemRead || MEM_MemWrite) && !dmem_ready) begin
                m_mode = 1; m_waits = 1;
            end
        end else if (m_mode == 1) begin
            if (dmem_ready) m_mode = 0;
            else if (m_waits >= TO) m_mode = 2;
            else m_waits++;
        end
        cycle++;
    end

    always @(negedge clk) begin
        logic [72:0] act, exp_v;
        act   = {PCSrc, PCtarget, PCwrite, IDwrite, IDflush, EXflush, MEMflush, pipe_hold, dmem_req, mem_err};
        exp_v = model_out();
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL model_cmp cycle=%0d got=%h expected=%h", cycle, act, exp_v);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    task automatic idle();
        ID_rs1Reg = 0; ID_rs2Reg = 0; EX_rdReg = 0; EX_MemRead = 0;
        MEM_Branch = 0; MEM_Jump = 0; MEM_zero = 0; MEM_s_less = 0; MEM_u_less = 0;
        MEM_funct3 = 0; MEM_PCSum = 64'h40; MEM_MemRead = 0; MEM_MemWrite = 0; dmem_ready = 0;
    endtask

    task automatic to_neg();
        @(negedge clk);
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1; to_neg(); next(); reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout cycle=%0d", cycle);
        $fatal(1);
    end

    initial begin
        idle(); reset = 1;
        to_neg();
        chk("reset_pcwrite", 64'(PCwrite), 1);
        chk("reset_hold", 64'(pipe_hold), 0);
        chk("reset_err", 64'(mem_err), 0);
        next(); reset = 0;

        // beq taken, then funct3=010 with every flag set
        MEM_Branch = 1; MEM_funct3 = 3'b000; MEM_zero = 1; MEM_PCSum = 64'h80;
        to_neg();
        chk("beq_pcsrc", 64'(PCSrc), 1);
        chk("beq_target", PCtarget, 64'h80);
        chk("beq_flush", 64'({IDflush, EXflush, MEMflush}), 64'h7);
        next();
        MEM_funct3 = 3'b010; MEM_s_less = 1; MEM_u_less = 1;
        to_neg();
        chk("f010_pcsrc", 64'(PCSrc), 0);
        chk("f010_flush", 64'({IDflush, EXflush, MEMflush}), 0);
        next();

        idle(); MEM_Branch = 1; MEM_funct3 = 3'b110; MEM_u_less = 1;
        to_neg(); chk("bltu_pcsrc", 64'(PCSrc), 1); next();
        idle(); MEM_Branch = 1; MEM_funct3 = 3'b101; MEM_s_less = 1;
        to_neg(); chk("bge_pcsrc", 64'(PCSrc), 0); next();
        idle(); MEM_Branch = 1; MEM_funct3 = 3'b001; MEM_zero = 0;
        to_neg(); chk("bne_pcsrc", 64'(PCSrc), 1); next();

        // load-use
        idle(); EX_MemRead = 1; EX_rdReg = 5; ID_rs2Reg = 5; ID_rs1Reg = 3;
        to_neg();
        chk("lu_stall", 64'({PCwrite, IDwrite, EXflush, IDflush}), 64'b0010);
        next();
        EX_rdReg = 0; ID_rs1Reg = 0;
        to_neg();
        chk("lu_x0", 64'({PCwrite, IDwrite, EXflush}), 64'b110);
        next();
        EX_rdReg = 5; MEM_Jump = 1;
        to_neg();
        chk("lu_jump", 64'({PCSrc, PCwrite, IDwrite, IDflush, EXflush, MEMflush}), 64'b111111);
        next();

        // memory wait: 3 not-ready cycles then ready
        begin
            int holds = 0, reqs = 0;
            idle(); MEM_MemRead = 1;
            for (int i = 0; i < 4; i++) begin
                dmem_ready = (i == 3);
                to_neg();
                holds += pipe_hold; reqs += dmem_req;
                next();
            end
            chk("wait_holds", 64'(holds), 3);
            chk("wait_reqs", 64'(reqs), 4);
        end
        idle(); MEM_MemWrite = 1; dmem_ready = 1;
        to_neg();
        chk("ready_now_hold", 64'(pipe_hold), 0);
        chk("ready_now_req", 64'(dmem_req), 1);
        next();
        idle(); to_neg(); chk("back_run_pcwrite", 64'(PCwrite), 1); next();

        // timeout
        idle(); MEM_MemRead = 1;
        for (int i = 0; i < 5; i++) begin
            to_neg();
            chk("to_hold", 64'({pipe_hold, mem_err}), 64'b10);
            next();
        end
        to_neg();
        chk("to_err", 64'({mem_err, dmem_req, PCwrite, pipe_hold}), 64'b1001);
        next();
        idle(); dmem_ready = 1; MEM_Jump = 1;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            chk("err_sticky", 64'({mem_err, PCSrc}), 64'b10);
            next();
        end
        idle();
        do_reset();
        to_neg();
        chk("err_cleared", 64'({mem_err, PCwrite, pipe_hold}), 64'b010);
        next();

        // deferred redirect behind a store
        do_reset();
        MEM_Branch = 1; MEM_funct3 = 0; MEM_zero = 1; MEM_MemWrite = 1; MEM_PCSum = 64'h1000;
        for (int i = 0; i < 2; i++) begin
            to_neg();
            chk("defer_nosrc", 64'({PCSrc, pipe_hold}), 64'b01);
            next();
        end
        dmem_ready = 1;
        to_neg();
        chk("defer_release", 64'({PCSrc, pipe_hold, MEMflush}), 64'b101);
        chk("defer_target", PCtarget, 64'h1000);
        next();
        idle();
        to_neg();
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_wait", 64'(perf_wait_cyc), 2);
        chk("perf_redir", 64'(perf_redir_cnt), 1);
        chk("perf_stall", 64'(perf_stall_cyc), 2);
        chk("perf_lu", 64'(perf_lu_cnt), 0);
`endif
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline.
- Resolves branches and jumps using the MEM-stage flags from the EX/MEM register, and produces the PC redirect plus the IF/ID, ID/EX and EX/MEM flushes.
- Detects load-use hazards between ID and EX.
- Sequences variable-latency data-memory accesses through a ready handshake, with a timeout watchdog.

Parameters:
- MEM_TIMEOUT, 16: maximum number of MEMWAIT cycles before a fatal error (range 2..255).
- CNT_W, 32: width of the performance counters (used only when the optional feature is on).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ID_rs1Reg  in  5  rs1 of the instruction in ID
- ID_rs2Reg  in  5  rs2 of the instruction in ID
- EX_MemRead  in  1  instruction in EX is a load
- EX_rdReg  in  5  destination register of EX
- MEM_Branch  in  1  conditional branch in MEM
- MEM_Jump  in  1  jal/jalr in MEM
- MEM_zero  in  1  ALU zero flag
- MEM_s_less  in  1  signed less-than flag
- MEM_u_less  in  1  unsigned less-than flag
- MEM_funct3  in  3  branch type
- MEM_PCSum  in  64  branch/jump target
- MEM_MemRead  in  1  load in MEM
- MEM_MemWrite  in  1  store in MEM
- dmem_ready  in  1  data memory completes the access this cycle
- PCSrc  out  1  select PCtarget as next PC
- PCtarget  out  64  redirect address
- PCwrite  out  1  PC update enable
- IDwrite  out  1  IF/ID load enable
- IDflush  out  1  clear IF/ID
- EXflush  out  1  clear ID/EX (insert bubble)
- MEMflush  out  1  clear EX/MEM
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB
- dmem_req  out  1  data memory request
- mem_err  out  1  sticky timeout error

Behaviour:
- States: RUN, MEMWAIT, ERROR. Reset puts the block in RUN and clears the wait counter and mem_err.
- All outputs are combinational from the state and inputs; the outputs evaluated with reset=1 apply normally.
- Idle output values:
  - PCSrc=0, IDflush=0, EXflush=0, MEMflush=0, pipe_hold=0, dmem_req=0
  - PCwrite=1, IDwrite=1
  - PCtarget=MEM_PCSum at all times
- Access condition: acc = MEM_MemRead | MEM_MemWrite. dmem_req = acc in RUN and in MEMWAIT; dmem_req=0 in ERROR.
- Hold:
  - pipe_hold = acc & ~dmem_ready, in RUN or MEMWAIT.
  - While pipe_hold=1: PCwrite=0, IDwrite=0, and all flushes are 0.
  - An access with dmem_ready=1 in the same cycle completes with no stall.
- RUN:
  - acc & ~dmem_ready causes a transition to MEMWAIT and sets the wait counter to 1.
- MEMWAIT:
  - dmem_ready=1 causes a return to RUN; hold drops in that same cycle.
  - Otherwise the counter increments.
  - When the counter equals MEM_TIMEOUT while ready is still low, the block goes to ERROR.
- ERROR:
  - PCwrite=0, IDwrite=0, pipe_hold=1, mem_err=1.
  - Only reset exits this state.
- Branch condition by funct3:
  - 000 taken = zero
  - 001 taken = ~zero
  - 100 taken = s_less
  - 101 taken = ~s_less
  - 110 taken = u_less
  - 111 taken = ~u_less
  - 010 and 011 are never taken.
- Redirect: redir = MEM_Jump | (MEM_Branch & taken), evaluated only when pipe_hold=0 and the state is not ERROR. When redir=1: PCSrc=1, IDflush=1, EXflush=1, MEMflush=1.
- Load-use: lu = EX_MemRead & (EX_rdReg != 0) & (EX_rdReg == ID_rs1Reg | EX_rdReg == ID_rs2Reg). When lu=1: PCwrite=0, IDwrite=0, EXflush=1.
- Priority: ERROR > pipe_hold > redir > lu.
  - A redirect coinciding with a load-use asserts only the redirect outputs (PCwrite=1).
  - A redirect coinciding with a hold is deferred until the hold releases, because the MEM contents stay frozen.
- Branch or jump asserted together with acc is illegal; it is handled by the priority order above.
- Reset asserted in MEMWAIT or ERROR returns the block to RUN on the next edge; the counter and mem_err clear.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- When defined, add outputs perf_stall_cyc, perf_lu_cnt, perf_redir_cnt and perf_wait_cyc, each CNT_W bits.
  - perf_stall_cyc: incremented each cycle PCwrite=0.
  - perf_lu_cnt: incremented each cycle lu wins arbitration.
  - perf_redir_cnt: incremented each cycle redir wins arbitration.
  - perf_wait_cyc: incremented each cycle pipe_hold=1.
  - All four saturate at all-ones and clear on reset.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- beq taken: MEM_Branch=1, funct3=000, zero=1, MEM_PCSum=0x80 -> same cycle PCSrc=1, PCtarget=0x80, IDflush=EXflush=MEMflush=1. Repeat with funct3=010, taken set -> no redirect.
- bltu/bge sweep: funct3=110 with u_less=1 -> taken. funct3=101 with s_less=1 -> not taken. funct3=001 with zero=0 -> taken.
- Load-use: EX_MemRead=1, EX_rdReg=5, ID_rs2Reg=5 -> PCwrite=0, IDwrite=0, EXflush=1. Same with EX_rdReg=0 -> no stall. Add MEM_Jump=1 in the same cycle -> redirect only, PCwrite=1.
- Memory wait: MEM_MemRead=1, dmem_ready low for 3 cycles then high -> pipe_hold=1 for exactly 3 cycles, dmem_req=1 for 4 cycles, state back to RUN. With ready high immediately -> zero stall cycles.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low -> ERROR entered after 4 MEMWAIT cycles, mem_err=1 stays set. Assert reset for 1 cycle -> mem_err=0, state RUN, PCwrite=1.
- Deferred redirect plus perf counters (with PIPE_HAZARD_PERF_EN): MEM_Branch taken together with MEM_MemWrite, ready low for 2 cycles -> no PCSrc during the hold, PCSrc=1 in the release cycle. Afterwards perf_wait_cyc=2 and perf_redir_cnt=1.
